// File: rtl/alu_pkg.sv
// ALU shared definitions: datapath width and opcode encodings.
// Used by alu_if, alu_adder and alu.
package alu_pkg;

    localparam int WIDTH = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_BAND = 4'b0101;
    localparam logic [3:0] OP_BOR  = 4'b0110;
    localparam logic [3:0] OP_LAND = 4'b0111;
    localparam logic [3:0] OP_LOR  = 4'b1000;
    localparam logic [3:0] OP_BXOR = 4'b1001;
    localparam logic [3:0] OP_BNOT = 4'b1010;
    localparam logic [3:0] OP_LNOT = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_SHL  = 4'b1101;
    localparam logic [3:0] OP_INC  = 4'b1110;
    localparam logic [3:0] OP_DEC  = 4'b1111;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle.
// master drives operands and opcode; slave (the ALU) drives results.
interface alu_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] Carry;
    logic             Sign;
    logic             Zero;
    logic             Parity;
    logic             Overflow;
    logic             Carry_fin;

    modport master (
        output a, b, opcode,
        input  op, Carry, Sign, Zero, Parity, Overflow, Carry_fin
    );

    modport slave (
        input  a, b, opcode,
        output op, Carry, Sign, Zero, Parity, Overflow, Carry_fin
    );

endinterface

// File: rtl/alu_adder.sv
// 16-bit ripple-carry adder exposing the carry out of every bit.
// Shared by add, sub, increment and decrement.
module alu_adder
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    // Ripple chain: each stage takes the previous stage's carry.
    always_comb begin
        logic c;
        c = cin;
        sum = '0;
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            carry[i] = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
            c = carry[i];
        end
    end

endmodule

// File: rtl/alu.sv
// 16-bit ALU with registered result, carry vector and flags.
// Define ALU_MULDIV_EN to build the multiply/divide/modulo opcodes.
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    logic [WIDTH-1:0] ax, ay, asum, acarry;
    logic             acin;
    logic [WIDTH-1:0] res, cv;
    logic             cf, ov;
    logic [WIDTH-1:0] op_q, carry_q;
    logic             sign_q, zero_q, par_q, ov_q, cf_q;

`ifdef ALU_MULDIV_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
`endif

    // Adder operand steering: sub is a + ~b + 1, dec is a + FFFF.
    always_comb begin
        ax = bus.a;
        ay = bus.b;
        acin = 1'b0;
        case (bus.opcode)
            OP_SUB: begin
                ay = ~bus.b;
                acin = 1'b1;
            end
            OP_INC: begin
                ay = '0;
                acin = 1'b1;
            end
            OP_DEC: ay = '1;
            default: ;
        endcase
    end

    alu_adder u_adder (
        .x     (ax),
        .y     (ay),
        .cin   (acin),
        .sum   (asum),
        .carry (acarry)
    );

    // Result, carry and overflow selection per opcode.
    always_comb begin
        res = '0;
        cv = '0;
        cf = 1'b0;
        ov = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                res = asum;
                cv = acarry;
                cf = acarry[WIDTH-1];
                ov = (ax[WIDTH-1] == ay[WIDTH-1]) &&
                     (asum[WIDTH-1] != ax[WIDTH-1]);
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                res = prod[WIDTH-1:0];
                ov = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                res = (bus.b == '0) ? '1 : bus.a / bus.b;
                ov = (bus.b == '0);
            end
            OP_MOD: begin
                res = (bus.b == '0) ? '1 : bus.a % bus.b;
                ov = (bus.b == '0);
            end
`endif
            OP_BAND: res = bus.a & bus.b;
            OP_BOR:  res = bus.a | bus.b;
            OP_BXOR: res = bus.a ^ bus.b;
            OP_BNOT: res = ~bus.a;
            OP_LAND: res = {15'd0, (|bus.a) & (|bus.b)};
            OP_LOR:  res = {15'd0, (|bus.a) | (|bus.b)};
            OP_LNOT: res = {15'd0, ~(|bus.a)};
            OP_SHR: begin
                res = {1'b0, bus.a[WIDTH-1:1]};
                cf = bus.a[0];
            end
            OP_SHL: begin
                res = {bus.a[WIDTH-2:0], 1'b0};
                cf = bus.a[WIDTH-1];
            end
            default: ;
        endcase
    end

    // Output registers; async reset clears everything including Zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            carry_q <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            par_q <= 1'b0;
            ov_q <= 1'b0;
            cf_q <= 1'b0;
        end else begin
            op_q <= res;
            carry_q <= cv;
            sign_q <= res[WIDTH-1];
            zero_q <= (res == '0);
            par_q <= ^res;
            ov_q <= ov;
            cf_q <= cf;
        end
    end

    assign bus.op = op_q;
    assign bus.Carry = carry_q;
    assign bus.Sign = sign_q;
    assign bus.Zero = zero_q;
    assign bus.Parity = par_q;
    assign bus.Overflow = ov_q;
    assign bus.Carry_fin = cf_q;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu with hand-computed expectations.
// Expectations for opcodes 0010-0100 follow ALU_MULDIV_EN.
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [3:0] opc, input logic [15:0] a,
                       input logic [15:0] b);
        @(negedge clk);
        bus.opcode = opc;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic s, input logic z,
                         input logic p, input logic o, input logic c);
        chk({tag, ".flags"},
            {11'd0, bus.Sign, bus.Zero, bus.Parity, bus.Overflow,
             bus.Carry_fin},
            {11'd0, s, z, p, o, c});
    endtask

    initial begin
        bus.opcode = OP_ADD;
        bus.a = 16'h0000;
        bus.b = 16'h0000;
        #1;
        chk("rst.op", bus.op, 16'h0000);
        flags("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        run(OP_ADD, 16'hFFFF, 16'h0003);
        chk("add.op", bus.op, 16'h0002);
        chk("add.carry", bus.Carry, 16'hFFFF);
        flags("add", 0, 0, 1, 0, 1);

        run(OP_SUB, 16'h0003, 16'h0005);
        chk("sub.op", bus.op, 16'hFFFE);
        flags("sub", 1, 0, 1, 0, 0);

        run(OP_ADD, 16'h7FFF, 16'h0001);
        chk("addov.op", bus.op, 16'h8000);
        flags("addov", 1, 0, 1, 1, 0);

`ifdef ALU_MULDIV_EN
        run(OP_MUL, 16'h0004, 16'h0003);
        chk("mul.op", bus.op, 16'h000C);
        flags("mul", 0, 0, 0, 0, 0);
        run(OP_MUL, 16'h0100, 16'h0100);
        chk("mulov.op", bus.op, 16'h0000);
        flags("mulov", 0, 1, 0, 1, 0);
        run(OP_DIV, 16'h0010, 16'h0002);
        chk("div.op", bus.op, 16'h0008);
        run(OP_DIV, 16'h0010, 16'h0000);
        chk("div0.op", bus.op, 16'hFFFF);
        flags("div0", 1, 0, 0, 1, 0);
        run(OP_MOD, 16'h0007, 16'h0003);
        chk("mod.op", bus.op, 16'h0001);
`else
        run(OP_MUL, 16'h0004, 16'h0003);
        chk("mul.op", bus.op, 16'h0000);
        flags("mul", 0, 1, 0, 0, 0);
        run(OP_DIV, 16'h0010, 16'h0000);
        chk("div0.op", bus.op, 16'h0000);
        flags("div0", 0, 1, 0, 0, 0);
`endif

        run(OP_BAND, 16'hF0F0, 16'h0F0F);
        chk("band.op", bus.op, 16'h0000);
        flags("band", 0, 1, 0, 0, 0);
        run(OP_BOR, 16'hF0F0, 16'h0F0F);
        chk("bor.op", bus.op, 16'hFFFF);
        flags("bor", 1, 0, 0, 0, 0);
        run(OP_BXOR, 16'hF0F0, 16'h0F0F);
        chk("bxor.op", bus.op, 16'hFFFF);
        run(OP_BNOT, 16'h0F0F, 16'h1234);
        chk("bnot.op", bus.op, 16'hF0F0);
        run(OP_LAND, 16'h0001, 16'h0001);
        chk("land.op", bus.op, 16'h0001);
        run(OP_LAND, 16'h0100, 16'h0000);
        chk("land0.op", bus.op, 16'h0000);
        run(OP_LOR, 16'h0001, 16'h0000);
        chk("lor.op", bus.op, 16'h0001);
        run(OP_LNOT, 16'h0000, 16'hFFFF);
        chk("lnot.op", bus.op, 16'h0001);

        run(OP_SHR, 16'h8000, 16'h0000);
        chk("shr.op", bus.op, 16'h4000);
        flags("shr", 0, 0, 1, 0, 0);
        run(OP_SHR, 16'h0003, 16'h0000);
        chk("shr1.op", bus.op, 16'h0001);
        flags("shr1", 0, 0, 1, 0, 1);
        run(OP_SHL, 16'h4000, 16'h0000);
        chk("shl.op", bus.op, 16'h8000);
        flags("shl", 1, 0, 1, 0, 0);
        run(OP_SHL, 16'h8001, 16'h0000);
        chk("shl1.op", bus.op, 16'h0002);
        flags("shl1", 0, 0, 1, 0, 1);
        chk("shl1.carry", bus.Carry, 16'h0000);

        run(OP_INC, 16'h0001, 16'hFFFF);
        chk("inc.op", bus.op, 16'h0002);
        run(OP_DEC, 16'h0001, 16'h1234);
        chk("dec.op", bus.op, 16'h0000);
        flags("dec", 0, 1, 0, 0, 1);
        run(OP_DEC, 16'h0000, 16'h0000);
        chk("dec0.op", bus.op, 16'hFFFF);
        flags("dec0", 1, 0, 0, 0, 0);

        run(OP_ADD, 16'h0001, 16'h0001);
        chk("pre.op", bus.op, 16'h0002);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.op", bus.op, 16'h0000);
        chk("mid.carry", bus.Carry, 16'h0000);
        flags("mid", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.a = 16'h0002;
        @(posedge clk);
        #1;
        chk("post.op", bus.op, 16'h0003);
        chk("post.carry", bus.Carry, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
